// File: rtl/sc_ifetch_unit.sv
`default_nettype none
// sc_ifetch_unit: single-outstanding instruction fetch with req/ack memory handshake,
// next-PC selection on retire, and misalignment / ack-timeout fault detection. Rev 1.0
module sc_ifetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic        o_inst_valid,
  input  logic        i_retire,
  input  logic [1:0]  i_pcsource,
  input  logic [31:0] i_bpc,
  input  logic [31:0] i_ra,
  input  logic [31:0] i_jpc,
  output logic        o_fetch_fault,
  output logic [31:0] o_fetch_count
);

  localparam logic [31:0] C_TMO = TIMEOUT_CYC;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic [31:0] r_tcnt, w_tcnt_nxt;
  logic [31:0] w_pc4;
  logic [31:0] w_target;

  assign w_pc4 = r_pc + 32'd4;

  always_comb begin
    w_target = w_pc4;
    case (i_pcsource)
      2'b00:   w_target = w_pc4;
      2'b01:   w_target = i_bpc;
      2'b10:   w_target = i_ra;
      default: w_target = i_jpc;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_valid_nxt = r_valid;
    w_count_nxt = r_count;
    w_tcnt_nxt  = r_tcnt;
    case (r_state)
      S_RST: begin
        w_state_nxt = (RESET_PC[1:0] == 2'b00) ? S_REQ : S_FAULT;
      end
      S_REQ: begin
        if (i_imem_ack) begin
          w_inst_nxt  = i_imem_rdata;
          w_valid_nxt = 1'b1;
          w_count_nxt = r_count + 32'd1;
          w_state_nxt = S_HOLD;
        end else begin
          w_tcnt_nxt = r_tcnt + 32'd1;
          // This edge is the TIMEOUT_CYC-th cycle spent waiting without an ack
          if ((C_TMO != 32'd0) && (r_tcnt == C_TMO - 32'd1)) begin
            w_state_nxt = S_FAULT;
          end
        end
      end
      S_HOLD: begin
        if (i_retire && r_valid) begin
          w_pc_nxt    = w_target;
          w_valid_nxt = 1'b0;
          w_tcnt_nxt  = 32'd0;
          w_state_nxt = (w_target[1:0] == 2'b00) ? S_REQ : S_FAULT;
        end
      end
      S_FAULT: begin
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_RST;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= S_RST;
      r_pc    <= RESET_PC;
      r_inst  <= 32'd0;
      r_valid <= 1'b0;
      r_count <= 32'd0;
      r_tcnt  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_valid <= w_valid_nxt;
      r_count <= w_count_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  assign o_imem_req    = (r_state == S_REQ);
  assign o_imem_addr   = r_pc;
  assign o_inst        = r_inst;
  assign o_pc          = r_pc;
  assign o_pc4         = w_pc4;
  assign o_inst_valid  = r_valid;
  assign o_fetch_fault = (r_state == S_FAULT);
  assign o_fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sc_ifetch_unit.sv
`default_nettype none
// tb_sc_ifetch_unit: directed stimulus with queued expectations checked by a monitor.
module tb_sc_ifetch_unit;

  localparam logic [31:0] C_RPC = 32'h0040_0000;
  localparam int          C_TMO = 16;

  logic        clk;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst, pc, pc4;
  logic        inst_valid;
  logic        retire;
  logic [1:0]  pcsource;
  logic [31:0] bpc, ra, jpc;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  sc_ifetch_unit #(.RESET_PC(C_RPC), .TIMEOUT_CYC(C_TMO)) dut (
    .i_clk(clk), .i_resetn(resetn),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
    .o_inst(inst), .o_pc(pc), .o_pc4(pc4), .o_inst_valid(inst_valid),
    .i_retire(retire), .i_pcsource(pcsource),
    .i_bpc(bpc), .i_ra(ra), .i_jpc(jpc),
    .o_fetch_fault(fetch_fault), .o_fetch_count(fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] cnt;
  } exp_t;

  exp_t        inst_q[$];
  logic [31:0] addr_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  int   lat       = 1;
  int   wcnt      = 0;
  logic force_ack = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == C_RPC) return 32'h2008_0005;
    return (a ^ 32'h5A5A_0000) + 32'd3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // memory: ack after lat waiting cycles, garbage data otherwise
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (wcnt == lat) begin
          imem_ack   = 1'b1;
          imem_rdata = memf(imem_addr);
          wcnt       = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'hDEAD_BEEF;
          wcnt++;
        end
      end else begin
        imem_ack   = force_ack;
        imem_rdata = 32'hDEAD_BEEF;
        wcnt       = 0;
      end
    end
  end

  logic        m_prev_req   = 1'b0;
  logic        m_prev_valid = 1'b0;
  logic [31:0] m_prev_addr  = 32'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (imem_req && !m_prev_req) begin
        if (addr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req actual=%h expected=none", imem_addr);
        end else begin
          chk("req_addr", imem_addr, addr_q.pop_front());
        end
      end else if (imem_req && m_prev_req) begin
        chk("addr_stable", imem_addr, m_prev_addr);
      end
      if (inst_valid && !m_prev_valid) begin
        if (inst_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid actual=%h expected=none", inst);
        end else begin
          exp_t e;
          e = inst_q.pop_front();
          chk("inst", inst, e.inst);
          chk("pc", pc, e.pc);
          chk("pc4", pc4, e.pc4);
          chk("fetch_count", fetch_count, e.cnt);
        end
      end
      m_prev_req   = imem_req;
      m_prev_valid = inst_valid;
      m_prev_addr  = imem_addr;
    end
  end

  task automatic chk_reset_state();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_pc", pc, C_RPC);
    chk("rst_inst", inst, 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clk);
    chk_reset_state();
    @(negedge clk);
    exp_count = 32'd0;
  endtask

  task automatic wait_req(input string name, input int exp_n, input logic junk);
    int n;
    n = 0;
    while (imem_req && n < 200) begin
      n++;
      if (junk) begin
        retire   = 1'b1;
        pcsource = 2'b11;
        jpc      = 32'h0BAD_0000;
      end
      @(negedge clk);
    end
    retire = 1'b0;
    chk(name, n, exp_n);
  endtask

  task automatic release_and_fetch(input int l);
    lat       = l;
    exp_pc    = C_RPC;
    exp_count = exp_count + 32'd1;
    addr_q.push_back(C_RPC);
    inst_q.push_back(exp_t'{memf(C_RPC), C_RPC, C_RPC + 32'd4, exp_count});
    resetn = 1'b1;
    @(negedge clk);
    chk("req_after_reset", {31'd0, imem_req}, 32'd1);
    wait_req("req_cycles_boot", l + 1, 1'b0);
    chk("boot_valid", {31'd0, inst_valid}, 32'd1);
  endtask

  // expect_ok=1: fetch completes after exp_n request cycles; else a fault results
  task automatic do_retire(input logic [1:0] ps, input logic [31:0] tgt, input int l,
                           input int exp_n, input logic expect_ok, input logic junk);
    logic [31:0] nxt;
    lat = l;
    bpc = 32'h1111_1110; ra = 32'h2222_2220; jpc = 32'h3333_3330;
    case (ps)
      2'b00:   nxt = exp_pc + 32'd4;
      2'b01:   begin bpc = tgt; nxt = tgt; end
      2'b10:   begin ra  = tgt; nxt = tgt; end
      default: begin jpc = tgt; nxt = tgt; end
    endcase
    exp_pc = nxt;
    if (nxt[1:0] == 2'b00) addr_q.push_back(nxt);
    if (expect_ok) begin
      exp_count = exp_count + 32'd1;
      inst_q.push_back(exp_t'{memf(nxt), nxt, nxt + 32'd4, exp_count});
    end
    retire   = 1'b1;
    pcsource = ps;
    @(negedge clk);
    retire = 1'b0;
    chk("req_after_retire", {31'd0, imem_req}, {31'd0, (nxt[1:0] == 2'b00)});
    chk("pc_after_retire", pc, nxt);
    wait_req("req_cycles", exp_n, junk);
    if (expect_ok) begin
      chk("valid_after_fetch", {31'd0, inst_valid}, 32'd1);
    end else begin
      chk("fault_set", {31'd0, fetch_fault}, 32'd1);
      chk("fault_req", {31'd0, imem_req}, 32'd0);
      chk("fault_valid", {31'd0, inst_valid}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; retire = 1'b0; pcsource = 2'b00;
    bpc = 32'd0; ra = 32'd0; jpc = 32'd0;
    exp_pc = C_RPC; exp_count = 32'd0;
    repeat (2) @(negedge clk);
    do_reset();

    // boot fetch, then each pcsource selection with varied latency
    release_and_fetch(1);
    chk("boot_count", fetch_count, 32'd1);
    do_retire(2'b00, 32'd0,          0, 1, 1'b1, 1'b0);
    do_retire(2'b01, 32'h0040_0040,  1, 2, 1'b1, 1'b0);
    do_retire(2'b10, 32'h0040_0100,  2, 3, 1'b1, 1'b0);
    do_retire(2'b11, 32'h0040_0200,  0, 1, 1'b1, 1'b0);

    // slow ack, then an ack that never comes
    do_retire(2'b00, 32'd0,          5, 6, 1'b1, 1'b0);
    do_retire(2'b00, 32'd0,       1000, C_TMO, 1'b0, 1'b0);

    // misaligned branch target, then stray retire/ack pulses
    do_reset();
    release_and_fetch(0);
    do_retire(2'b01, 32'h0040_0042,  0, 0, 1'b0, 1'b0);
    retire = 1'b1; force_ack = 1'b1;
    repeat (4) @(negedge clk);
    retire = 1'b0; force_ack = 1'b0;
    chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    chk("fault_noreq", {31'd0, imem_req}, 32'd0);
    chk("fault_count", fetch_count, 32'd1);
    chk("fault_pc", pc, 32'h0040_0042);
    do_reset();

    // PC wrap at the top of the address space
    release_and_fetch(0);
    do_retire(2'b11, 32'hFFFF_FFFC,  1, 2, 1'b1, 1'b0);
    do_retire(2'b00, 32'd0,          0, 1, 1'b1, 1'b0);
    chk("wrap_count", fetch_count, 32'd3);

    // reset while a request is outstanding
    lat = 1000;
    addr_q.push_back(32'd4);
    retire = 1'b1; pcsource = 2'b00;
    @(negedge clk);
    retire = 1'b0;
    chk("midreq_req", {31'd0, imem_req}, 32'd1);
    do_reset();

    // reset while an instruction is valid
    release_and_fetch(0);
    do_reset();

    // retire while nothing is valid must be ignored
    release_and_fetch(2);
    do_retire(2'b00, 32'd0,          3, 4, 1'b1, 1'b1);
    chk("junk_pc", pc, C_RPC + 32'd4);

    repeat (2) @(negedge clk);
    chk("addr_q_drained", addr_q.size(), 32'd0);
    chk("inst_q_drained", inst_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
